// File: rtl/dsp_pkg.sv
// Shared widths and sequencer state encoding for the fir8_seq datapath.
package dsp_pkg;
    localparam int DW   = 16;
    localparam int CW   = 9;
    localparam int PW   = 25;
    localparam int NTAP = 8;
    localparam int OW   = 16;
    localparam int KW   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUM  = 2'd2,
        OUT  = 2'd3
    } state_e;
endpackage

// File: rtl/mul16x9s.sv
// Combinational signed 16x9 multiplier producing a 25-bit two's complement product.
module mul16x9s
    import dsp_pkg::*;
(
    input  logic signed [DW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    output logic signed [PW-1:0] p_o
);
    logic signed [PW-1:0] a_ext_s;
    logic signed [PW-1:0] b_ext_s;

    // Both operands are widened to the product width so the low PW bits are exact.
    assign a_ext_s = {{(PW-DW){a_i[DW-1]}}, a_i};
    assign b_ext_s = {{(PW-CW){b_i[CW-1]}}, b_i};
    assign p_o     = a_ext_s * b_ext_s;
endmodule

// File: rtl/fir8_seq.sv
// 8-tap FIR sequencer: one shared multiplier walks the taps, an external adder
// tree sums the held products, and the result leaves on a valid/ready port.
module fir8_seq
    import dsp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          coef_we,
    input  logic [KW-1:0] coef_addr,
    input  logic [CW-1:0] coef_data,
    output logic          coef_err,
    input  logic          flush,
    output logic [PW-1:0] add_d0,
    output logic [PW-1:0] add_d1,
    output logic [PW-1:0] add_d2,
    output logic [PW-1:0] add_d3,
    output logic [PW-1:0] add_d4,
    output logic [PW-1:0] add_d5,
    output logic [PW-1:0] add_d6,
    output logic [PW-1:0] add_d7,
    input  logic [OW-1:0] add_sum,
    output logic [OW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy
);
    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic signed [DW-1:0] tap_q  [NTAP];
    logic signed [DW-1:0] tap_d  [NTAP];
    logic signed [CW-1:0] coef_q [NTAP];
    logic signed [CW-1:0] coef_d [NTAP];
    logic signed [PW-1:0] prod_q [NTAP];
    logic signed [PW-1:0] prod_d [NTAP];
    logic [OW-1:0]        m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 coef_err_q, coef_err_d;
    logic signed [PW-1:0] prod_s;

    mul16x9s u_mul (
        .a_i (tap_q[k_q]),
        .b_i (coef_q[k_q]),
        .p_o (prod_s)
    );

    // Next-state, delay line, coefficient and product-register update.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        tap_d      = tap_q;
        coef_d     = coef_q;
        prod_d     = prod_q;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        coef_err_d = 1'b0;

        // A write in IDLE lands before the MUL pass of a sample accepted in the same cycle.
        if (coef_we) begin
            if (state_q == IDLE) begin
                coef_d[coef_addr] = coef_data;
            end else begin
                coef_err_d = 1'b1;
            end
        end else begin
            coef_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    for (int i = NTAP - 1; i > 0; i--) begin
                        tap_d[i] = tap_q[i-1];
                    end
                    tap_d[0] = s_data;
                    k_d      = 3'd0;
                    state_d  = MUL;
                end else if (flush) begin
                    for (int i = 0; i < NTAP; i++) begin
                        tap_d[i] = 16'sd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                prod_d[k_q] = prod_s;
                k_d         = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = SUM;
                end else begin
                    state_d = MUL;
                end
            end
            SUM: begin
                m_data_d  = add_sum;
                m_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= 3'd0;
            m_data_q   <= 16'd0;
            m_valid_q  <= 1'b0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < NTAP; i++) begin
                tap_q[i]  <= 16'sd0;
                coef_q[i] <= 9'sd0;
                prod_q[i] <= 25'sd0;
            end
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            coef_err_q <= coef_err_d;
            tap_q      <= tap_d;
            coef_q     <= coef_d;
            prod_q     <= prod_d;
        end
    end

    assign s_ready  = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
    assign coef_err = coef_err_q;
    assign add_d0   = prod_q[0];
    assign add_d1   = prod_q[1];
    assign add_d2   = prod_q[2];
    assign add_d3   = prod_q[3];
    assign add_d4   = prod_q[4];
    assign add_d5   = prod_q[5];
    assign add_d6   = prod_q[6];
    assign add_d7   = prod_q[7];
endmodule

// File: tb/tb_fir8_seq.sv
// Scoreboard bench for fir8_seq with a behavioural model of the external adder tree.
module tb_fir8_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s_data = 16'd0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = 3'd0;
    logic [8:0]  coef_data = 9'd0;
    logic        coef_err;
    logic        flush = 1'b0;
    logic [24:0] add_d0, add_d1, add_d2, add_d3, add_d4, add_d5, add_d6, add_d7;
    logic [15:0] add_sum;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    logic [31:0] sum_s;

    fir8_seq dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
        .flush(flush), .add_d0(add_d0), .add_d1(add_d1), .add_d2(add_d2), .add_d3(add_d3),
        .add_d4(add_d4), .add_d5(add_d5), .add_d6(add_d6), .add_d7(add_d7), .add_sum(add_sum),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sx(input logic [24:0] v);
        return {{7{v[24]}}, v};
    endfunction

    // External adder tree: 32-bit sum of the eight products, bits [31:16] returned.
    always_comb begin
        sum_s = sx(add_d0) + sx(add_d1) + sx(add_d2) + sx(add_d3)
              + sx(add_d4) + sx(add_d5) + sx(add_d6) + sx(add_d7);
        add_sum = sum_s[31:16];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake pops and compares one expected result.
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("m_data_unexpected", 32'(m_data), 32'hDEAD_BEEF);
            end else begin
                chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wr_coef(input logic [2:0] a, input logic [8:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
        chk("coef_err_idle", 32'(coef_err), 32'd0);
    endtask

    // Offer a sample, wait for it to be accepted; optionally check 9-edge latency.
    task automatic send(input logic [15:0] d, input logic [15:0] exp, input bit push, input bit lat);
        bit got = 1'b0;
        s_data = d; s_valid = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (s_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        if (push) exp_q.push_back(exp);
        @(posedge clk); #1;
        s_valid = 1'b0; coef_we = 1'b0;
        if (lat) begin
            repeat (8) @(posedge clk);
            #1 chk("lat_pre", 32'(m_valid), 32'd0);
            @(posedge clk);
            #1 chk("lat_rise", 32'(m_valid), 32'd1);
        end
    endtask

    task automatic wait_out();
        bit got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (m_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("out_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk); #1;
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic impulse();
        wr_coef(3'd0, 9'd128);
        wr_coef(3'd1, 9'd64);
        send(16'd16384, 16'h0020, 1'b1, 1'b1);
        send(16'd0,     16'h0010, 1'b1, 1'b1);
        send(16'd0,     16'h0000, 1'b1, 1'b1);
        wait_idle();
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_add_d0", 32'(add_d0), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        impulse();

        // Extreme product.
        wr_coef(3'd0, 9'h100);
        wr_coef(3'd1, 9'd0);
        send(16'h8000, 16'h0080, 1'b1, 1'b1);
        wait_idle();
        chk("extreme_add_d0", 32'(add_d0), 32'h0080_0000);

        // Truncation toward minus infinity.
        wr_coef(3'd0, 9'd1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        wait_idle();
        chk("trunc_add_d0", 32'(add_d0), 32'h01FF_FFFF);

        // Backpressure with a pending sample.
        wr_coef(3'd0, 9'd200);
        m_ready = 1'b0;
        send(16'h4000, 16'h0032, 1'b1, 1'b0);
        wait_out();
        s_data = 16'h1000; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_m_data", 32'(m_data), 32'h0032);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(m_valid), 32'd0);
        chk("bp_release_ready", 32'(s_ready), 32'd1);
        exp_q.push_back(16'h000C);
        @(posedge clk); #1;
        chk("bp_next_accept", 32'(busy), 32'd1);
        s_valid = 1'b0;
        wait_out();
        wait_idle();

        // Coefficient write during MUL is dropped.
        send(16'h2000, 16'h0019, 1'b1, 1'b0);
        @(posedge clk); #1;
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 9'd5;
        @(posedge clk); #1;
        coef_we = 1'b0;
        chk("busy_coef_err_hi", 32'(coef_err), 32'd1);
        @(posedge clk); #1;
        chk("busy_coef_err_lo", 32'(coef_err), 32'd0);
        wait_out();
        wait_idle();
        send(16'h2000, 16'h0019, 1'b1, 1'b1);
        wait_idle();
        // Write together with accept uses the new coefficient.
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 9'd3;
        send(16'h7FFF, 16'h0001, 1'b1, 1'b1);
        wait_idle();

        // Asynchronous reset at k=4.
        send(16'h1234, 16'h0000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_s_ready", 32'(s_ready), 32'd1);
        chk("mid_rst_add_d0", 32'(add_d0), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        impulse();

        for (int n = 0; n < 40; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
